// File: rtl/cpu_mem_arbiter.sv
// Two-client (fetch / data-cache) arbiter onto one memory_controller_interface port; one transaction in flight.
// Optional round-robin arbitration under CPU_MEM_ARBITER_RR_EN; default build is fixed priority, d over if.
`timescale 1ns/1ps

package cpu_mem_arbiter_pkg;
    typedef struct packed {
        logic         valid;
        logic         rw;
        logic [31:0]  addr;
        logic [127:0] data;
    } mci_request_t;

    typedef struct packed {
        logic         ready;
        logic [127:0] data;
    } mci_response_t;
endpackage

module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int RESP_TIMEOUT = 0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  mci_request_t  i_if_req,
    output mci_response_t o_if_res,
    input  mci_request_t  i_d_req,
    output mci_response_t o_d_res,
    output mci_request_t  o_mem_req,
    input  mci_response_t i_mem_res,
    output logic          o_busy,
    output logic          o_owner,
    output logic          o_timeout
);

    localparam int CW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(RESP_TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t       r_state;
    mci_request_t r_mem_req;
    logic         r_owner;
    logic         r_timeout;
    logic [CW-1:0] r_wdog;

    logic          w_any_vld;
    logic          w_grant_d;
    logic          w_mem_rdy;
    logic [CW-1:0] w_wdog_nxt;

    assign w_any_vld = i_if_req.valid || i_d_req.valid;

`ifdef CPU_MEM_ARBITER_RR_EN
    // r_rr_ptr holds the last-served client; on a tie the other one wins
    logic r_rr_ptr;
    assign w_grant_d = i_d_req.valid && (!i_if_req.valid || !r_rr_ptr);
`else
    assign w_grant_d = i_d_req.valid;
`endif

    assign w_wdog_nxt = (r_wdog == TMO) ? r_wdog : r_wdog + 1'b1;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_mem_req <= '0;
            r_owner   <= 1'b0;
            r_timeout <= 1'b0;
            r_wdog    <= '0;
`ifdef CPU_MEM_ARBITER_RR_EN
            r_rr_ptr  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_vld) begin
                        r_mem_req       <= w_grant_d ? i_d_req : i_if_req;
                        r_mem_req.valid <= 1'b1;
                        r_owner         <= w_grant_d;
                        r_state         <= BUSY;
`ifdef CPU_MEM_ARBITER_RR_EN
                        r_rr_ptr        <= w_grant_d;
`endif
                    end
                end
                BUSY: begin
                    // The watchdog only flags; the transaction is never aborted
                    if (RESP_TIMEOUT != 0 && w_wdog_nxt == TMO) begin
                        r_timeout <= 1'b1;
                    end
                    if (i_mem_res.ready) begin
                        r_mem_req.valid <= 1'b0;
                        r_wdog          <= '0;
                        r_state         <= RELEASE;
                    end else begin
                        r_wdog <= w_wdog_nxt;
                    end
                end
                RELEASE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_mem_rdy = (r_state == BUSY) && i_mem_res.ready;

    always_comb begin
        o_if_res       = '0;
        o_d_res        = '0;
        o_if_res.data  = i_mem_res.data;
        o_d_res.data   = i_mem_res.data;
        o_if_res.ready = w_mem_rdy && !r_owner;
        o_d_res.ready  = w_mem_rdy && r_owner;
    end

    assign o_mem_req = r_mem_req;
    assign o_busy    = (r_state != IDLE);
    assign o_owner   = r_owner;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter with RESP_TIMEOUT = 8; honours CPU_MEM_ARBITER_RR_EN for tie-break expectations.
`timescale 1ns/1ps

module tb_cpu_mem_arbiter;
    import cpu_mem_arbiter_pkg::*;

    logic          i_clk = 1'b0;
    logic          i_reset;
    mci_request_t  i_if_req, i_d_req, o_mem_req;
    mci_response_t o_if_res, o_d_res, i_mem_res;
    logic          o_busy, o_owner, o_timeout;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] DATA1 = {32'h13, 32'h12, 32'h11, 32'h10};
    localparam logic [127:0] WDATA = 128'hDEADBEEF;

    cpu_mem_arbiter #(.RESP_TIMEOUT(8)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_if_req(i_if_req), .o_if_res(o_if_res),
        .i_d_req(i_d_req), .o_d_res(o_d_res),
        .o_mem_req(o_mem_req), .i_mem_res(i_mem_res),
        .o_busy(o_busy), .o_owner(o_owner), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    function automatic mci_request_t mkreq(logic v, logic rw, logic [31:0] a, logic [127:0] d);
        mci_request_t r;
        r.valid = v; r.rw = rw; r.addr = a; r.data = d;
        return r;
    endfunction

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            @(negedge i_clk);
            if (o_mem_req.valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_if_req = '0; i_d_req = '0; i_mem_res = '0;
        repeat (2) @(negedge i_clk);
        total++; if (o_mem_req !== '0) begin bad++; $display("FAIL rst_mem_req got=%h exp=0", o_mem_req); end
        total++; if ({o_busy, o_owner, o_timeout} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {o_busy, o_owner, o_timeout}); end
        i_reset = 1'b0;
        @(negedge i_clk);
        total++; if ({o_if_res.ready, o_d_res.ready, o_busy} !== 3'b000) begin bad++; $display("FAIL rst_ready got=%b exp=000", {o_if_res.ready, o_d_res.ready, o_busy}); end
    endtask

    task automatic test_single_read();
        cyc();
        i_if_req = mkreq(1'b1, 1'b0, 32'h40, '0);
        @(negedge i_clk);
        total++; if (o_mem_req.valid !== 1'b0) begin bad++; $display("FAIL t1_pre_grant got=%b exp=0", o_mem_req.valid); end
        cyc();
        @(negedge i_clk);
        total++; if (o_mem_req.valid !== 1'b1) begin bad++; $display("FAIL t1_grant_vld got=%b exp=1", o_mem_req.valid); end
        total++; if (o_mem_req.addr !== 32'h40) begin bad++; $display("FAIL t1_addr got=%h exp=40", o_mem_req.addr); end
        total++; if ({o_busy, o_owner} !== 2'b10) begin bad++; $display("FAIL t1_busy_owner got=%b exp=10", {o_busy, o_owner}); end
        for (int k = 2; k <= 4; k++) begin
            cyc();
            @(negedge i_clk);
            total++; if (o_if_res.ready !== 1'b0) begin bad++; $display("FAIL t1_early_ready cyc=%0d got=%b exp=0", k, o_if_res.ready); end
        end
        cyc();
        i_mem_res.ready = 1'b1; i_mem_res.data = DATA1;
        @(negedge i_clk);
        total++; if (o_if_res.ready !== 1'b1) begin bad++; $display("FAIL t1_if_ready got=%b exp=1", o_if_res.ready); end
        total++; if (o_if_res.data !== DATA1) begin bad++; $display("FAIL t1_if_data got=%h exp=%h", o_if_res.data, DATA1); end
        total++; if (o_d_res.ready !== 1'b0) begin bad++; $display("FAIL t1_d_ready got=%b exp=0", o_d_res.ready); end
        cyc();
        i_mem_res.ready = 1'b0; i_if_req.valid = 1'b0;
        @(negedge i_clk);
        total++; if ({o_if_res.ready, o_mem_req.valid, o_busy} !== 3'b001) begin bad++; $display("FAIL t1_release got=%b exp=001", {o_if_res.ready, o_mem_req.valid, o_busy}); end
        cyc();
        @(negedge i_clk);
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL t1_idle got=%b exp=0", o_busy); end
    endtask

    task automatic test_simultaneous();
        logic exp_owner [4];
        int   left_if, left_d;
        bit   ok;
`ifdef CPU_MEM_ARBITER_RR_EN
        exp_owner = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_owner = '{1'b1, 1'b1, 1'b0, 1'b0};
`endif
        left_if = 2; left_d = 2;
        cyc();
        i_if_req = mkreq(1'b1, 1'b0, 32'h100, '0);
        i_d_req  = mkreq(1'b1, 1'b1, 32'h8000, WDATA);
        for (int g = 0; g < 4; g++) begin
            wait_grant(ok);
            total++; if (!ok) begin bad++; $display("FAIL sim_grant_timeout g=%0d got=0 exp=1", g); end
            total++; if (o_owner !== exp_owner[g]) begin bad++; $display("FAIL sim_owner g=%0d got=%b exp=%b", g, o_owner, exp_owner[g]); end
            total++; if (o_mem_req.addr !== (exp_owner[g] ? 32'h8000 : 32'h100)) begin bad++; $display("FAIL sim_addr g=%0d got=%h", g, o_mem_req.addr); end
            if (g == 0) begin
                total++; if ({o_mem_req.rw, o_mem_req.data} !== {1'b1, WDATA}) begin bad++; $display("FAIL sim_write got=%b/%h exp=1/%h", o_mem_req.rw, o_mem_req.data, WDATA); end
            end
            cyc(); cyc();
            i_mem_res.ready = 1'b1; i_mem_res.data = 128'(g);
            @(negedge i_clk);
            total++; if ({o_d_res.ready, o_if_res.ready} !== (exp_owner[g] ? 2'b10 : 2'b01)) begin bad++; $display("FAIL sim_ready g=%0d got=%b", g, {o_d_res.ready, o_if_res.ready}); end
            cyc();
            i_mem_res.ready = 1'b0;
            if (exp_owner[g]) begin left_d--; i_d_req.valid = (left_d > 0); end
            else begin left_if--; i_if_req.valid = (left_if > 0); end
        end
        cyc(); cyc();
        @(negedge i_clk);
        total++; if ({o_busy, o_mem_req.valid} !== 2'b00) begin bad++; $display("FAIL sim_end_idle got=%b exp=00", {o_busy, o_mem_req.valid}); end
    endtask

    task automatic test_drop_valid();
        cyc();
        i_if_req = mkreq(1'b1, 1'b0, 32'h200, '0);
        cyc();
        cyc(); cyc();
        i_if_req.valid = 1'b0;
        @(negedge i_clk);
        total++; if ({o_mem_req.valid, o_mem_req.addr} !== {1'b1, 32'h200}) begin bad++; $display("FAIL drop_held got=%b/%h exp=1/200", o_mem_req.valid, o_mem_req.addr); end
        cyc(); cyc();
        i_mem_res.ready = 1'b1; i_mem_res.data = 128'h55;
        @(negedge i_clk);
        total++; if (o_if_res.ready !== 1'b1) begin bad++; $display("FAIL drop_ready got=%b exp=1", o_if_res.ready); end
        cyc();
        i_mem_res.ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            total++; if (o_mem_req.valid !== 1'b0) begin bad++; $display("FAIL drop_regrant k=%0d got=%b exp=0", k, o_mem_req.valid); end
            cyc();
        end
    endtask

    task automatic test_stray_ready();
        i_mem_res.ready = 1'b1; i_mem_res.data = 128'hAA;
        @(negedge i_clk);
        total++; if ({o_if_res.ready, o_d_res.ready} !== 2'b00) begin bad++; $display("FAIL stray_fwd got=%b exp=00", {o_if_res.ready, o_d_res.ready}); end
        cyc();
        i_mem_res.ready = 1'b0;
        @(negedge i_clk);
        total++; if ({o_busy, o_mem_req.valid} !== 2'b00) begin bad++; $display("FAIL stray_state got=%b exp=00", {o_busy, o_mem_req.valid}); end
    endtask

    task automatic test_timeout();
        logic exp_t;
        total++; if (o_timeout !== 1'b0) begin bad++; $display("FAIL tmo_pre got=%b exp=0", o_timeout); end
        cyc();
        i_if_req = mkreq(1'b1, 1'b0, 32'h300, '0);
        for (int k = 1; k <= 20; k++) begin
            cyc();
            @(negedge i_clk);
            exp_t = (k > 8);
            total++; if (o_timeout !== exp_t) begin bad++; $display("FAIL tmo_busy k=%0d got=%b exp=%b", k, o_timeout, exp_t); end
        end
        cyc();
        i_mem_res.ready = 1'b1; i_mem_res.data = 128'h77;
        @(negedge i_clk);
        total++; if ({o_if_res.ready, o_timeout} !== 2'b11) begin bad++; $display("FAIL tmo_late_ready got=%b exp=11", {o_if_res.ready, o_timeout}); end
        cyc();
        i_mem_res.ready = 1'b0; i_if_req.valid = 1'b0;
        cyc(); cyc();
        @(negedge i_clk);
        total++; if ({o_timeout, o_busy} !== 2'b10) begin bad++; $display("FAIL tmo_sticky got=%b exp=10", {o_timeout, o_busy}); end
    endtask

    task automatic test_reset_mid_busy();
        bit ok;
        cyc();
        i_if_req = mkreq(1'b1, 1'b0, 32'h400, '0);
        cyc();
        cyc();
        i_mem_res.ready = 1'b1; i_mem_res.data = 128'h99;
        #1;
        total++; if (o_if_res.ready !== 1'b1) begin bad++; $display("FAIL rmid_pre_ready got=%b exp=1", o_if_res.ready); end
        #1 i_reset = 1'b1;
        #1;
        total++; if ({o_mem_req.valid, o_busy, o_if_res.ready, o_d_res.ready} !== 4'b0000) begin bad++; $display("FAIL rmid_async got=%b exp=0000", {o_mem_req.valid, o_busy, o_if_res.ready, o_d_res.ready}); end
        total++; if ({o_owner, o_timeout} !== 2'b00) begin bad++; $display("FAIL rmid_flags got=%b exp=00", {o_owner, o_timeout}); end
        i_mem_res.ready = 1'b0; i_if_req = '0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        cyc();
        i_if_req = mkreq(1'b1, 1'b0, 32'h500, '0);
        wait_grant(ok);
        total++; if (!ok || o_mem_req.addr !== 32'h500) begin bad++; $display("FAIL rmid_regrant got=%b/%h exp=1/500", ok, o_mem_req.addr); end
        cyc();
        i_mem_res.ready = 1'b1; i_mem_res.data = DATA1;
        @(negedge i_clk);
        total++; if ({o_if_res.ready, o_d_res.ready, o_if_res.data} !== {2'b10, DATA1}) begin bad++; $display("FAIL rmid_serve got=%b%b/%h", o_if_res.ready, o_d_res.ready, o_if_res.data); end
        cyc();
        i_mem_res.ready = 1'b0; i_if_req.valid = 1'b0;
        cyc(); cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_drop_valid();
        test_stray_ready();
        test_timeout();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
